// File: rtl/ahb_params_pkg.sv
// Shared AHB bus widths, encodings and helpers for the memory slave and its interface.
package ahb_params_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int NO_OF_SLAVES  = 4;
  localparam int NO_OF_MASTERS = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Sizes above a word are rejected separately, so they never count as misaligned here.
  function automatic logic misaligned(input logic [1:0] addrLsb, input logic [2:0] size);
    case (size)
      HSIZE_HALF: return addrLsb[0];
      HSIZE_WORD: return addrLsb != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_if.sv
// AHB bus bundle with master and slave views of the shared signals.
interface ahb_if import ahb_params_pkg::*;;

  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic                             HWRITE;
  logic [2:0]                       HSIZE;
  logic [2:0]                       HBURST;
  logic [3:0]                       HPROT;
  logic [DATA_WIDTH-1:0]            HWDATA;
  logic [NO_OF_SLAVES-1:0]          HSEL;
  logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER;
  logic                             HMASTLOCK;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic                             HREADY;
  logic [1:0]                       HRESP;
  logic [NO_OF_MASTERS-1:0]         HSPLIT;

  modport master_mp (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
           HSEL, HMASTER, HMASTLOCK,
    input  HRDATA, HREADY, HRESP, HSPLIT
  );

  modport slave_mp (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
           HSEL, HMASTER, HMASTLOCK,
    output HRDATA, HREADY, HRESP, HSPLIT
  );

endinterface

// File: rtl/ahb_slave_mem.sv
// Word RAM with per-byte write enables: synchronous write, combinational read.
module ahb_slave_mem #(
  parameter  int DEPTH = 256,
  parameter  int DW    = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [IW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_modport_slave.sv
// AHB memory slave on the ahb_if slave modport with a two-cycle ERROR response.
// Define AHB_SLV_WAIT_STATE_EN to add WAIT_STATES cycles of HREADY=0 to every OKAY transfer.
module ahb_modport_slave import ahb_params_pkg::*; #(
  parameter int unsigned           SLAVE_INDEX = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           MEM_DEPTH   = 256,
  parameter int unsigned           WAIT_STATES = 2
) (
  input logic    HCLK,
  input logic    HRESETn,
  ahb_if.slave_mp bus
);

  localparam int                    IW        = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * DATA_WIDTH / 8);
  localparam int                    CW        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
`ifdef AHB_SLV_WAIT_STATE_EN
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES);
`else
  localparam logic [CW-1:0] WAIT_LOAD = '0;
`endif

  slv_state_e            state_q, state_d;
  logic [IW+1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  addrErr, hready, complete;
  hresp_e                hresp;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] rdata;

  // Addresses below the window wrap to huge offsets and fall out of range too.
  assign offset  = bus.HADDR - BASE_ADDR;
  assign addrErr = (offset >= MEM_BYTES) || (bus.HSIZE > HSIZE_WORD)
                 || misaligned(bus.HADDR[1:0], bus.HSIZE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    wait_d   = wait_q;
    hready   = 1'b1;
    hresp    = HRESP_OKAY;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_ACCESS: begin
        if (wait_q != '0) begin
          hready = 1'b0;
          wait_d = wait_q - CW'(1);
        end else begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A completing cycle may also accept the next address phase (pipelined transfers).
    if (bus.HSEL[SLAVE_INDEX] && bus.HTRANS[1] && hready) begin
      addr_d  = offset[IW+1:0];
      write_d = bus.HWRITE;
      size_d  = bus.HSIZE;
      wait_d  = WAIT_LOAD;
      state_d = addrErr ? ST_ERR1 : ST_ACCESS;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      HSIZE_BYTE: be = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
  end

  always_comb begin
    hrdata = hrdata_q;
    if (state_q == ST_ACCESS && !write_q) hrdata = rdata;
    else if (state_q == ST_ERR1 || state_q == ST_ERR2) hrdata = '0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wait_q   <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      wait_q   <= wait_d;
      hrdata_q <= hrdata;
    end
  end

  ahb_slave_mem #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (complete && write_q),
    .be_i    (be),
    .waddr_i (addr_q[IW+1:2]),
    .wdata_i (bus.HWDATA),
    .raddr_i (addr_q[IW+1:2]),
    .rdata_o (rdata)
  );

  assign bus.HRDATA = hrdata;
  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HSPLIT = '0;

  logic unused_sigs;
  assign unused_sigs = ^{bus.HBURST, bus.HPROT, bus.HMASTER, bus.HMASTLOCK, bus.HSEL, bus.HTRANS};

endmodule

// File: tb/tb_ahb_modport_slave.sv
// Self-checking bench for ahb_modport_slave: directed plan steps plus random traffic
// scored against a byte-array memory model.
module tb_ahb_modport_slave;

`ifdef AHB_SLV_WAIT_STATE_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic clk = 1'b0;
  logic rstN;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [7:0]  refMem [0:1023];
  logic [31:0] lastRead;

  ahb_if bus ();

  ahb_modport_slave #(
    .SLAVE_INDEX (0),
    .BASE_ADDR   (32'h0000_0000),
    .MEM_DEPTH   (256),
    .WAIT_STATES (2)
  ) dut (
    .HCLK    (clk),
    .HRESETn (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic void modelWrite(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    int n = 1 << size;
    for (int k = 0; k < n; k++) begin
      int a = int'(addr) + k;
      refMem[a] = data[8*(a%4) +: 8];
    end
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    int w = int'(addr) & ~3;
    return {refMem[w+3], refMem[w+2], refMem[w+1], refMem[w]};
  endfunction

  function automatic logic isLegal(input logic [31:0] addr, input logic [2:0] size);
    if (addr >= 32'd1024 || size > 3'd2) return 1'b0;
    return (addr % (32'd1 << size)) == 0;
  endfunction

  task automatic busIdle();
    bus.HSEL      = 4'b0000;
    bus.HTRANS    = 2'b00;
    bus.HWRITE    = 1'b0;
    bus.HADDR     = 32'h0;
    bus.HSIZE     = 3'b010;
    bus.HBURST    = 3'b000;
    bus.HPROT     = 4'b0000;
    bus.HMASTER   = '0;
    bus.HMASTLOCK = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [2:0] size);
    bus.HSEL   = 4'b0001;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
  endtask

  task automatic waitReady(output int waits);
    waits = 0;
    @(negedge clk);
    while (bus.HREADY !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
  endtask

  task automatic doOkay(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata);
    int waits;
    applyStimulus(addr, wr, size);
    @(posedge clk); #1;
    busIdle();
    bus.HWDATA = wdata;
    waitReady(waits);
    checkOutput("okay_waits", 32'(waits), 32'(EXP_WAIT));
    checkOutput("okay_resp", 32'(bus.HRESP), 32'h0);
    if (!wr) begin
      lastRead = bus.HRDATA;
      checkOutput("read_data", bus.HRDATA, modelRead(addr));
    end
    @(posedge clk); #1;
    if (wr) modelWrite(addr, size, wdata);
  endtask

  task automatic doError(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata);
    applyStimulus(addr, wr, size);
    @(posedge clk); #1;
    busIdle();
    bus.HWDATA = wdata;
    @(negedge clk);
    checkOutput("err1_ready", 32'(bus.HREADY), 32'h0);
    checkOutput("err1_resp", 32'(bus.HRESP), 32'h1);
    checkOutput("err1_rdata", bus.HRDATA, 32'h0);
    @(negedge clk);
    checkOutput("err2_ready", 32'(bus.HREADY), 32'h1);
    checkOutput("err2_resp", 32'(bus.HRESP), 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic checkQuiet(input string tag);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(bus.HREADY), 32'h1);
    checkOutput({tag, "_resp"}, 32'(bus.HRESP), 32'h0);
    checkOutput({tag, "_split"}, 32'(bus.HSPLIT), 32'h0);
    @(posedge clk); #1;
    bus.HWDATA = 32'hBAD0_BAD0;
  endtask

  initial begin
    int waits;
    busIdle();
    bus.HWDATA = '0;
    rstN = 1'b0;
    #2;
    checkOutput("reset_ready", 32'(bus.HREADY), 32'h1);
    checkOutput("reset_resp", 32'(bus.HRESP), 32'h0);
    checkOutput("reset_rdata", bus.HRDATA, 32'h0);
    checkOutput("reset_split", 32'(bus.HSPLIT), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) doOkay(32'(i * 4), 1'b1, 3'b010, $urandom);

    doOkay(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF);
    doOkay(32'h10, 1'b0, 3'b010, 32'h0);
    checkOutput("word_readback", lastRead, 32'hDEAD_BEEF);
    doOkay(32'h11, 1'b1, 3'b000, 32'h0000_AB00);
    doOkay(32'h10, 1'b0, 3'b010, 32'h0);
    checkOutput("byte_merge", lastRead, 32'hDEAD_ABEF);

    doError(32'h400, 1'b0, 3'b010, 32'h0);
    doError(32'h02, 1'b1, 3'b010, 32'h5555_5555);
    doError(32'h01, 1'b1, 3'b011, 32'h6666_6666);
    doOkay(32'h00, 1'b0, 3'b010, 32'h0);

    bus.HSEL = 4'b0001; bus.HTRANS = 2'b00; bus.HWRITE = 1'b1; bus.HADDR = 32'h20;
    checkQuiet("idle");
    bus.HTRANS = 2'b01;
    checkQuiet("busy");
    bus.HSEL = 4'b0010; bus.HTRANS = 2'b10;
    checkQuiet("unsel");
    busIdle();
    checkQuiet("quiet");
    doOkay(32'h20, 1'b0, 3'b010, 32'h0);

    // Back-to-back: write then pipelined read of the same word.
    applyStimulus(32'h30, 1'b1, 3'b010);
    @(posedge clk); #1;
    applyStimulus(32'h30, 1'b0, 3'b010);
    bus.HWDATA = 32'hCAFE_F00D;
    waitReady(waits);
    checkOutput("b2b_a_waits", 32'(waits), 32'(EXP_WAIT));
    @(posedge clk); #1;
    modelWrite(32'h30, 3'b010, 32'hCAFE_F00D);
    busIdle();
    waitReady(waits);
    checkOutput("b2b_b_waits", 32'(waits), 32'(EXP_WAIT));
    checkOutput("b2b_b_rdata", bus.HRDATA, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset while a write data phase is pending must leave the word untouched.
    applyStimulus(32'h40, 1'b1, 3'b010);
    @(posedge clk); #1;
    busIdle();
    bus.HWDATA = 32'h1234_5678;
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(bus.HREADY), 32'h1);
    checkOutput("midrst_resp", 32'(bus.HRESP), 32'h0);
    checkOutput("midrst_rdata", bus.HRDATA, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    doOkay(32'h40, 1'b0, 3'b010, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      logic        wr;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        size = 3'($urandom_range(0, 2));
        addr = 32'($urandom_range(0, 255) * 4) + ((32'($urandom_range(0, 3))) & ~((32'd1 << size) - 1));
      end else begin
        size = 3'($urandom_range(0, 3));
        addr = 32'($urandom_range(0, 32'h41F));
      end
      if (isLegal(addr, size)) doOkay(addr, wr, size, $urandom);
      else doError(addr, wr, size, $urandom);
    end

    for (int i = 0; i < 8; i++) doOkay(32'(i * 4), 1'b0, 3'b010, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ahb_modport_slave.md
Name: ahb_modport_slave

Overview:
AHB (AHB2-style, 2-bit HRESP) memory-mapped slave implementing the slave side of the ahb_if slave_mp modport. It decodes its HSEL bit and serves read/write transfers from an internal byte-addressable word RAM. It optionally inserts wait states and returns a two-cycle ERROR response for illegal accesses. It sits behind the bus decoder, alongside the arbiter and the other slaves.

Parameters:
ADDR_WIDTH, 32, address bus width (from ahb_params_pkg)
DATA_WIDTH, 32, data bus width (from ahb_params_pkg)
NO_OF_SLAVES, 4, width of HSEL
NO_OF_MASTERS, 2, width of HSPLIT and HMASTER
SLAVE_INDEX, 0, HSEL bit owned by this slave
BASE_ADDR, 32'h0000_0000, first byte address of the memory window
MEM_DEPTH, 256, number of DATA_WIDTH words
WAIT_STATES, 2, wait cycles per transfer when AHB_SLV_WAIT_STATE_EN is defined

Ports:
HCLK  in  1  clock, rising edge
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  in  1  1=write
HSIZE  in  3  000 byte, 001 half, 010 word
HBURST  in  3  burst type, ignored functionally
HPROT  in  4  ignored
HWDATA  in  DATA_WIDTH  write data, valid in the data phase
HSEL  in  NO_OF_SLAVES  one-hot select
HMASTER  in  $clog2(NO_OF_MASTERS)  ignored
HMASTLOCK  in  1  ignored
HRDATA  out  DATA_WIDTH  read data
HREADY  out  1  transfer done / wait control
HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never issued
HSPLIT  out  NO_OF_MASTERS  always 0

Behaviour:
- Reset (async, HRESETn=0): HREADY=1, HRESP=OKAY, HRDATA=0, HSPLIT=0, FSM=IDLE. A pending data phase is aborted and no RAM write occurs.
- Address phase is captured on a rising HCLK edge when all of the following hold: HSEL[SLAVE_INDEX]=1, HTRANS[1]=1 (NONSEQ or SEQ), and HREADY=1.
- Captured fields are registered: addr, write, size, and err.
- err=1 if any of these holds:
  - offset = HADDR-BASE_ADDR is at or above MEM_DEPTH*DATA_WIDTH/8;
  - HSIZE is above 010;
  - HADDR is misaligned for HSIZE.
- IDLE, BUSY, or an unselected slave gives OKAY with zero wait, and no capture.
- FSM states: IDLE, ACCESS, ERR1, ERR2.
  - IDLE to ACCESS on a valid capture; IDLE to ERR1 on a capture with err=1.
  - ACCESS: HREADY=0 while the wait counter is nonzero, HRESP=OKAY. When the counter is zero, HREADY=1 and the transfer completes.
  - ACCESS exits to IDLE, or directly to ACCESS/ERR1 if a new address phase is captured at the completing edge (pipelined back-to-back transfers).
  - ERR1: HREADY=0, HRESP=ERROR, then to ERR2.
  - ERR2: HREADY=1, HRESP=ERROR, then to IDLE, or to a new capture.
- Write: HWDATA is sampled at the completing edge of the data phase. Only the byte lanes selected by size and addr[1:0] are written (little-endian). Byte: lane addr[1:0]. Half: lanes {addr[1],0} and {addr[1],1}.
- Read: HRDATA = RAM word at addr, driven combinationally during the data phase and valid when HREADY=1. The full word is returned; the master selects the lanes.
- HRDATA outside a read data phase holds its last value.
- Read after write to the same address in the next transfer returns the new data.
- Errored transfers never modify the RAM. ERROR-response HRDATA is don't-care; drive 0.

Optional Feature:
Macro AHB_SLV_WAIT_STATE_EN.
- Defined: every OKAY transfer gets WAIT_STATES cycles of HREADY=0 before its completing cycle.
- Undefined: zero-wait; ACCESS completes in its first cycle. ERROR timing is two cycles in both cases.

Decomposition:
- ahb_params_pkg holds ADDR_WIDTH, DATA_WIDTH, NO_OF_SLAVES, NO_OF_MASTERS, htrans_e, hresp_e, hsize_e.
- Sub-module ahb_slave_mem: synchronous-write, async-read word RAM with byte enables.

Test Plan:
- Reset mid-write: assert HRESETn=0 while in ACCESS with a pending write -> HREADY=1, HRESP=00, HRDATA=0 immediately, and the word is unchanged.
- Word write then read: write 32'hDEADBEEF to 0x10, then read 0x10 -> HRDATA=DEADBEEF, HRESP=00, zero-wait without the macro.
- Byte write: write HSIZE=000 to 0x11 with HWDATA=32'h0000AB00, then read 0x10 -> DEADABEF.
- Illegal access: read at offset MEM_DEPTH*4 (0x400), or word access at 0x02 -> HREADY 0 then 1 with HRESP=01 for two cycles, and memory is untouched.
- Wait states: with AHB_SLV_WAIT_STATE_EN and WAIT_STATES=2, a write -> HREADY=0 for 2 cycles, then 1. Back-to-back NONSEQ transfers are both served.
- IDLE/BUSY/unselected: HTRANS=00 or 01, or HSEL[SLAVE_INDEX]=0 -> HREADY=1, HRESP=00, HSPLIT=0, no RAM change.
